// File: rtl/board_link_pkg.sv
// -----------------------------------------------------------------------------
// board_link_pkg
// Shared definitions for the inter-board serial link (transmitter and receiver).
//   BOARD_BITS      : packed board state width (81 cells x 2 bits)
//   DEF_BIT_PERIOD  : default clk cycles per serial bit (100 kbit/s at 65 MHz)
//   DEF_STOP_BITS   : default number of idle-high stop bits per frame
//   START_LEVEL     : line level of the start bit
//   IDLE_LEVEL      : line level while idle and during stop bits
//   IDX_W           : bit index width (covers WIDTH+3)
//   tx_state_t      : transmitter FSM states
// -----------------------------------------------------------------------------
package board_link_pkg;

    localparam int BOARD_BITS     = 162;
    localparam int DEF_BIT_PERIOD = 650;
    localparam int DEF_STOP_BITS  = 2;
    localparam int IDX_W          = 8;

    localparam logic START_LEVEL = 1'b0;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/link_bit_timer.sv
// -----------------------------------------------------------------------------
// link_bit_timer
// Free-running bit timer: counts 0..BIT_PERIOD-1 and wraps, held at 0 while
// clear_in is high. tick_out is high for the single cycle in which the count
// sits at its terminal value.
// Ports:
//   clk_in    : system clock
//   rst_in    : synchronous active-high reset
//   clear_in  : hold the count at zero
//   count_out : current count
//   tick_out  : terminal-count pulse
// -----------------------------------------------------------------------------
module link_bit_timer #(
    parameter int BIT_PERIOD = 650,
    parameter int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             clear_in,
    output logic [CNT_W-1:0] count_out,
    output logic             tick_out
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             terminal;

    assign terminal = (count_q == CNT_W'(BIT_PERIOD - 1));

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear_in || terminal) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;
    assign tick_out  = terminal && !clear_in;

endmodule

// File: rtl/board_link_tx.sv
// -----------------------------------------------------------------------------
// board_link_tx
// UART-style, LSB-first serial transmitter for the inter-board link. Latches
// the packed board state on a start request in IDLE and sends
//   start bit (0), WIDTH data bits, [parity bit], STOP_BITS stop bits (1).
// Optional feature macro: BOARD_LINK_PARITY_EN adds an even-parity bit after
// the data bits (parity computed from the latched value).
// Ports:
//   clk_in     : system clock
//   rst_in     : synchronous active-high reset
//   trigger_in : start request, honoured only in IDLE
//   val_in     : board bus, sampled in the accepting cycle only
//   data_out   : serial line, idles high (registered)
//   busy_out   : high while a frame is in flight (registered)
//   done_out   : pulse in the final cycle of the last stop bit (registered)
// -----------------------------------------------------------------------------
module board_link_tx
    import board_link_pkg::*;
#(
    parameter int WIDTH      = BOARD_BITS,
    parameter int BIT_PERIOD = DEF_BIT_PERIOD,
    parameter int STOP_BITS  = DEF_STOP_BITS
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             trigger_in,
    input  logic [WIDTH-1:0] val_in,
    output logic             data_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

    tx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             data_q,  data_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
`ifdef BOARD_LINK_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic [CNT_W-1:0] bit_count;
    logic             bit_tick;

    link_bit_timer #(
        .BIT_PERIOD (BIT_PERIOD),
        .CNT_W      (CNT_W)
    ) u_bit_timer (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (state_q == IDLE),
        .count_out (bit_count),
        .tick_out  (bit_tick)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef BOARD_LINK_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (trigger_in) begin
                    state_d = START;
                    shift_d = val_in;
                    idx_d   = '0;
`ifdef BOARD_LINK_PARITY_EN
                    parity_d = ^val_in;
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        idx_d = '0;
`ifdef BOARD_LINK_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef BOARD_LINK_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Registered outputs are derived from the next state so the line level
    // changes on the same edge as the state register.
    always_comb begin
        data_d = IDLE_LEVEL;
        case (state_d)
            START:   data_d = START_LEVEL;
            DATA:    data_d = shift_d[0];
`ifdef BOARD_LINK_PARITY_EN
            PARITY:  data_d = parity_d;
`endif
            default: data_d = IDLE_LEVEL;
        endcase
        busy_d = (state_d != IDLE);
        // One cycle early so the registered pulse lands on the terminal cycle.
        done_d = (state_q == STOP) &&
                 (idx_q == IDX_W'(STOP_BITS - 1)) &&
                 (bit_count == CNT_W'(BIT_PERIOD - 2));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            data_q  <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BOARD_LINK_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BOARD_LINK_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign data_out = data_q;
    assign busy_out = busy_q;
    assign done_out = done_q;

endmodule

// File: tb/tb_board_link_tx.sv
// -----------------------------------------------------------------------------
// tb_board_link_tx
// Self-checking bench for board_link_tx with BIT_PERIOD=4, STOP_BITS=2.
// Cycle k of a frame is the k-th clock cycle after the cycle in which the
// trigger was presented; outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_board_link_tx;

    localparam int W  = 162;
    localparam int BP = 4;
    localparam int SB = 2;
`ifdef BOARD_LINK_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int L = BP * (1 + W + P + SB);

    logic         clk = 1'b0;
    logic         rst;
    logic         trig;
    logic [W-1:0] val;
    logic         data;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    board_link_tx #(
        .WIDTH      (W),
        .BIT_PERIOD (BP),
        .STOP_BITS  (SB)
    ) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .trigger_in (trig),
        .val_in     (val),
        .data_out   (data),
        .busy_out   (busy),
        .done_out   (done)
    );

    int total = 0;
    int bad   = 0;
    logic [2:0] obs [0:1023];

    typedef struct {
        int   cyc;
        logic d;
        logic b;
        logic o;
    } probe_t;

    probe_t tab [$];

    // Expected {data, busy, done} at frame cycle k for a latched value v.
    function automatic logic [2:0] exp_out(logic [W-1:0] v, int k);
        int   b;
        logic d;
        if (k < 1 || k > L) return 3'b100;
        b = (k - 1) / BP;
        if (b == 0)                        d = 1'b0;
        else if (b <= W)                   d = v[b-1];
        else if (P == 1 && b == W + 1)     d = ^v;
        else                               d = 1'b1;
        return {d, 1'b1, (k == L)};
    endfunction

    function automatic logic [W-1:0] rand_v();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check3(string name, int k, logic [2:0] got, logic [2:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s cycle %0d: got data/busy/done=%b required %b", name, k, got, req);
        end
    endtask

    task automatic check_int(string name, int got, int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // Presents trigger with v in the current cycle, then checks cycles 1..L+1.
    // From cycle chg on, val_in switches to v2; trigger pulses at t1 and t2.
    task automatic run_frame(string name, logic [W-1:0] v, int chg,
                             logic [W-1:0] v2, int t1, int t2);
        trig = 1'b1;
        val  = v;
        for (int k = 1; k <= L + 1; k++) begin
            step();
            obs[k] = {data, busy, done};
            check3(name, k, obs[k], exp_out(v, k));
            trig = (k == t1) || (k == t2);
            if (k >= chg) val = v2;
        end
        trig = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] v2;
        int           dones;
        int           starts;
        int           nexp;
        int           off;
        int           last_c;
        logic         busy_prev;

        // Probe table for val_in = 1 (only bit 0 set).
        tab.push_back('{1,   1'b0, 1'b1, 1'b0});
        tab.push_back('{4,   1'b0, 1'b1, 1'b0});
        tab.push_back('{5,   1'b1, 1'b1, 1'b0});
        tab.push_back('{8,   1'b1, 1'b1, 1'b0});
        tab.push_back('{9,   1'b0, 1'b1, 1'b0});
        tab.push_back('{652, 1'b0, 1'b1, 1'b0});
        tab.push_back('{653, 1'b1, 1'b1, 1'b0});
`ifdef BOARD_LINK_PARITY_EN
        tab.push_back('{656, 1'b1, 1'b1, 1'b0});
        tab.push_back('{660, 1'b1, 1'b1, 1'b0});
        tab.push_back('{663, 1'b1, 1'b1, 1'b0});
        tab.push_back('{664, 1'b1, 1'b1, 1'b1});
        tab.push_back('{665, 1'b1, 1'b0, 1'b0});
`else
        tab.push_back('{659, 1'b1, 1'b1, 1'b0});
        tab.push_back('{660, 1'b1, 1'b1, 1'b1});
        tab.push_back('{661, 1'b1, 1'b0, 1'b0});
`endif

        // Reset, with a trigger that reset must swallow.
        rst  = 1'b1;
        trig = 1'b1;
        val  = '1;
        step();
        step();
        rst  = 1'b0;
        trig = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check3("reset", k, {data, busy, done}, 3'b100);
        end

        // Single-one frame against the probe table.
        v = '0;
        v[0] = 1'b1;
        run_frame("one", v, L + 10, v, 0, 0);
        foreach (tab[i]) begin
            check3("table", tab[i].cyc, obs[tab[i].cyc], {tab[i].d, tab[i].b, tab[i].o});
        end

        // Alternating pattern; val_in flips to all ones 10 cycles in.
        v = {81{2'b10}};
        run_frame("alt", v, 10, '1, 0, 0);

        // Triggers at cycle 100 and in the done cycle are dropped; the next
        // frame is accepted in the first idle cycle.
        v = rand_v();
        run_frame("drop", v, L + 10, v, 100, L);
        run_frame("b2b", rand_v(), L + 10, v, 0, 0);

        // Reset mid-frame at cycle 300, together with a trigger.
        v = rand_v();
        trig = 1'b1;
        val  = v;
        for (int k = 1; k <= 300; k++) begin
            step();
            check3("pre_rst", k, {data, busy, done}, exp_out(v, k));
            trig = 1'b0;
        end
        rst  = 1'b1;
        trig = 1'b1;
        step();
        rst  = 1'b0;
        trig = 1'b0;
        check3("rst_mid", 301, {data, busy, done}, 3'b100);
        dones = 0;
        for (int k = 302; k <= 301 + L; k++) begin
            step();
            if (done) dones++;
            if (busy) check3("rst_idle", k, {data, busy, done}, 3'b100);
        end
        check_int("rst_no_done", dones, 0);
        run_frame("after_rst", rand_v(), L + 10, v, 0, 0);

        // Parity-relevant values: three ones, then all zeros.
        v = '0;
        v[3] = 1'b1;
        v[77] = 1'b1;
        v[161] = 1'b1;
        run_frame("three", v, L + 10, v, 0, 0);
        run_frame("zero", '0, L + 10, '0, 0, 0);

        // Random frames with random late val_in changes and dropped triggers.
        for (int r = 0; r < 4; r++) begin
            v  = rand_v();
            v2 = rand_v();
            run_frame("rand", v, $urandom_range(L, 1), v2,
                      $urandom_range(L, 1), $urandom_range(L, 1));
            repeat ($urandom_range(3, 0)) begin
                step();
                check3("rand_idle", 0, {data, busy, done}, 3'b100);
            end
        end

        // Trigger held high for 2000 cycles: back-to-back frames, one idle
        // cycle between them.
        v      = rand_v();
        nexp   = 1999 / (L + 1) + 1;
        last_c = (nexp - 1) * (L + 1) + L + 1;
        dones  = 0;
        starts = 0;
        busy_prev = 1'b0;
        trig = 1'b1;
        val  = v;
        for (int c = 1; c <= last_c; c++) begin
            step();
            off = c - ((c - 1) / (L + 1)) * (L + 1);
            check3("held", c, {data, busy, done}, exp_out(v, off));
            if (done) dones++;
            if (busy && !busy_prev) starts++;
            busy_prev = busy;
            if (c == 1999) trig = 1'b0;
        end
        trig = 1'b0;
        check_int("held_frames", starts, nexp);
        check_int("held_dones", dones, nexp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
